// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: one-shot capture of four selectable ADC streams into readout buffers, optionally aligned to SYSREF.
module adc_capture_sequencer #(
    parameter int NBEATS_W = 16
) (
    input  logic                aclk,
    input  logic                rst_i,
    input  logic                capture_i,
    input  logic                abort_i,
    input  logic                sync_en_i,
    input  logic                sysref_i,
    input  logic [11:0]         src_sel_i,
    input  logic [NBEATS_W-1:0] length_i,
    input  logic [1023:0]       adc_tdata,
    input  logic [7:0]          adc_tvalid,
    output logic [7:0]          adc_tready,
    output logic [511:0]        buf_tdata,
    output logic [3:0]          buf_tvalid,
    input  logic [3:0]          buf_tready,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o
);
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, FLUSH} state_t;
    state_t state, state_nx;
    logic [11:0] sel;
    logic [NBEATS_W-1:0] len, cnt;
    logic sysref_q, accept, all_valid, take, drop;
    assign adc_tready = '1;
    assign accept = (state == IDLE) && capture_i;
    assign take = (state == CAPTURE) && all_valid && !abort_i;
    assign drop = |(buf_tvalid & ~buf_tready);
    always_comb begin
        all_valid = 1'b1;
        for (int n = 0; n < 4; n++) all_valid = all_valid & adc_tvalid[sel[3*n +: 3]];
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = capture_i ? (sync_en_i ? ARM : CAPTURE) : IDLE;
            ARM:     state_nx = abort_i ? IDLE : (sysref_i && !sysref_q) ? CAPTURE : ARM;
            CAPTURE: state_nx = abort_i ? IDLE : (take && cnt == len) ? FLUSH : CAPTURE;
            default: state_nx = IDLE;
        endcase
    end
    // Buffer lanes register the selected ADC word, giving exactly one cycle of latency.
    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            sel        <= '0;
            len        <= '0;
            cnt        <= '0;
            sysref_q   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
            buf_tvalid <= '0;
            buf_tdata  <= '0;
        end else begin
            state      <= state_nx;
            sysref_q   <= sysref_i;
            busy_o     <= state_nx != IDLE;
            done_o     <= state == FLUSH;
            buf_tvalid <= {4{take}};
            overflow_o <= accept ? 1'b0 : (overflow_o | drop);
            if (accept) begin
                sel <= src_sel_i;
                len <= length_i;
                cnt <= '0;
            end else if (take) begin
                cnt <= cnt + 1'b1;
            end
            if (take)
                for (int n = 0; n < 4; n++) buf_tdata[128*n +: 128] <= adc_tdata[128*sel[3*n +: 3] +: 128];
        end
    end
endmodule
